// File: rtl/clk_period_meter_if.sv
// Signal bundle between a measured clock source (master) and clk_period_meter (slave).
interface clk_period_meter_if #(
    parameter int CNT_W = 27
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             locked;

    modport master (output sig_in, input period, period_valid, timeout, locked);
    modport slave  (input sig_in, output period, period_valid, timeout, locked);
endinterface

// File: rtl/clk_period_meter.sv
// Edge-to-edge period meter for a slow square wave, with timeout and lock detection.
// Optional 4-sample averaging of the reported period when PERIOD_AVG_EN is defined.
//
// state   | meaning
// IDLE    | after reset, waiting for the first rising edge
// MEASURE | counting cycles between rising edges, reporting each interval
// TIMEOUT | no edge for TIMEOUT_CYC cycles; next edge restarts measurement
module clk_period_meter #(
    parameter int CNT_W         = 27,
    parameter int EXPECT_PERIOD = 50_000_000,
    parameter int TOL           = 1000,
    parameter int TIMEOUT_CYC   = 100_000_000
) (
    input  logic clock_50M,
    input  logic reset,
    clk_period_meter_if.slave meter_if
);
    typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

    localparam logic [CNT_W:0]   TOL_LO   = (CNT_W+1)'(EXPECT_PERIOD - TOL);
    localparam logic [CNT_W:0]   TOL_HI   = (CNT_W+1)'(EXPECT_PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;
    logic [1:0]       lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] meas;
    logic [CNT_W-1:0] result;
    logic             result_ok;
    logic             in_tol;

    assign rise = s2_q & ~s3_q;
    assign meas = cnt_q + CNT_W'(1);

`ifdef PERIOD_AVG_EN
    logic [CNT_W-1:0] hist_q [4];
    logic [CNT_W-1:0] hist_d [4];
    logic [CNT_W+1:0] sum_q, sum_d, sum_nxt;
    logic [2:0]       fill_q, fill_d;

    assign sum_nxt   = sum_q + (CNT_W+2)'(meas) - (CNT_W+2)'(hist_q[3]);
    assign result    = sum_nxt[CNT_W+1:2];
    assign result_ok = (fill_q >= 3'd3);
`else
    assign result    = meas;
    assign result_ok = 1'b1;
`endif

    assign in_tol = ({1'b0, result} >= TOL_LO) && ({1'b0, result} <= TOL_HI);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
`ifdef PERIOD_AVG_EN
        hist_d = hist_q;
        sum_d  = sum_q;
        fill_d = fill_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                // A rise on the threshold cycle is still a valid measurement.
                if (rise) begin
                    cnt_d = '0;
`ifdef PERIOD_AVG_EN
                    hist_d[0] = meas;
                    hist_d[1] = hist_q[0];
                    hist_d[2] = hist_q[1];
                    hist_d[3] = hist_q[2];
                    sum_d     = sum_nxt;
                    if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
`endif
                    if (result_ok) begin
                        period_d = result;
                        valid_d  = 1'b1;
                        if (in_tol) begin
                            lock_cnt_d = (lock_cnt_q == 2'd2) ? 2'd2 : lock_cnt_q + 2'd1;
                            locked_d   = (lock_cnt_d == 2'd2);
                        end else begin
                            lock_cnt_d = 2'd0;
                            locked_d   = 1'b0;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = TIMEOUT;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = 2'd0;
`ifdef PERIOD_AVG_EN
                    for (int i = 0; i < 4; i++) hist_d[i] = '0;
                    sum_d  = '0;
                    fill_d = 3'd0;
`endif
                end else begin
                    cnt_d = meas;
                end
            end
            TIMEOUT: begin
                if (rise) begin
                    state_d   = MEASURE;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_50M or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            s1_q       <= meter_if.sig_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

`ifdef PERIOD_AVG_EN
    always_ff @(posedge clock_50M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            sum_q  <= '0;
            fill_q <= 3'd0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end
`endif

    assign meter_if.period       = period_q;
    assign meter_if.period_valid = valid_q;
    assign meter_if.timeout      = timeout_q;
    assign meter_if.locked       = locked_q;
endmodule
